// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus bundle for the memory-mapped UART transmitter.
// The CPU drives the request side; the peripheral returns registered read data.
interface uart_tx_mmio_if;
  logic        ram_cen;
  logic        ram_wen;
  logic [3:0]  ram_flag;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    output ram_cen, ram_wen, ram_flag, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_cen, ram_wen, ram_flag, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divider, 8N1 framing.
// Optional parity bit is enabled at build time with the UART_TX_PARITY_EN macro.
//
// state    | meaning
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (low)
// S_DATA   | 8 data bits, LSB first
// S_PARITY | parity bit (UART_TX_PARITY_EN builds only)
// S_STOP   | stop bit (high)
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hE000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          txd,
  output logic          tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   reload_q, reload_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          txd_q, txd_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic          irq_en_q, irq_en_d;
`ifdef UART_TX_PARITY_EN
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          frame_par_q, frame_par_d;
  logic          par_bit_q, par_bit_d;
`endif

  logic [7:0] mem_q [FIFO_DEPTH];

  logic        win_hit, wr_en, rd_en;
  logic [3:0]  off;
  logic        push_req, push, pop, full, busy;
  logic [31:0] cnt_ext;
  logic        unused_bus;

  assign win_hit  = bus.ram_cen && (bus.ram_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = win_hit && bus.ram_wen;
  assign rd_en    = win_hit && !bus.ram_wen;
  assign off      = bus.ram_addr[3:0];
  assign push_req = wr_en && (off == 4'h4) && bus.ram_flag[0];
  assign full     = (count_q == FULL_CNT);
  assign push     = push_req && !full;
  assign busy     = (count_q != '0) || (state_q != S_IDLE);
  assign cnt_ext  = 32'(count_q);

  assign unused_bus = ^{bus.ram_wdata[31:16], bus.ram_flag[3:2]};

  // Register file: DIV, CTRL, sticky overflow, FIFO pointers, read mux.
  always_comb begin
    div_d    = div_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = '0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
`endif

    if (wr_en && off == 4'h8) begin
      if (bus.ram_flag[0]) div_d[7:0]  = bus.ram_wdata[7:0];
      if (bus.ram_flag[1]) div_d[15:8] = bus.ram_wdata[15:8];
    end
    if (wr_en && off == 4'hC && bus.ram_flag[0]) begin
      irq_en_d = bus.ram_wdata[0];
`ifdef UART_TX_PARITY_EN
      par_en_d  = bus.ram_wdata[1];
      par_odd_d = bus.ram_wdata[2];
`endif
    end

    // A push into a full FIFO is lost even when a pop frees a slot this cycle.
    if (push_req && full)
      ovf_d = 1'b1;
    else if (wr_en && off == 4'h0 && bus.ram_flag[0] && bus.ram_wdata[2])
      ovf_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (rd_en) begin
      case (off)
        4'h0:    rdata_d = {16'h0, cnt_ext[7:0], 5'b0, ovf_q, busy, full};
        4'h8:    rdata_d = {16'h0, div_q};
`ifdef UART_TX_PARITY_EN
        4'hC:    rdata_d = {29'h0, par_odd_q, par_en_q, irq_en_q};
`else
        4'hC:    rdata_d = {31'h0, irq_en_q};
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    reload_d  = reload_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    frame_par_d = frame_par_q;
    par_bit_d   = par_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          reload_d = div_q;
          timer_d  = div_q;
          txd_d    = 1'b0;
          state_d  = S_START;
`ifdef UART_TX_PARITY_EN
          frame_par_d = par_en_q;
          par_bit_d   = (^mem_q[rd_ptr_q]) ^ par_odd_q;
`endif
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          timer_d   = reload_q;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          timer_d = reload_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (frame_par_q) begin
              txd_d   = par_bit_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            // shift_q[0] is always the bit currently on the line
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_q == '0) begin
          timer_d = reload_q;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    irq_d = irq_en_q && (count_q == '0) && (state_q == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      reload_q  <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      irq_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      frame_par_q <= 1'b0;
      par_bit_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      irq_en_q  <= irq_en_d;
`ifdef UART_TX_PARITY_EN
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      frame_par_q <= frame_par_d;
      par_bit_q   <= par_bit_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ram_wdata[7:0];
  end

  assign txd           = txd_q;
  assign tx_irq        = irq_q;
  assign bus.ram_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, framing, FIFO overflow, IRQ, reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_mmio;
  logic clk;
  logic rst;
  logic txd;
  logic tx_irq;
  int   n_vec;
  int   n_err;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .txd    (txd),
    .tx_irq (tx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] BASE = 32'hE000_0000;

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] flag);
    bus_if.ram_cen   = 1'b1;
    bus_if.ram_wen   = 1'b1;
    bus_if.ram_addr  = addr;
    bus_if.ram_wdata = data;
    bus_if.ram_flag  = flag;
    @(negedge clk);
    bus_if.ram_cen   = 1'b0;
    bus_if.ram_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_if.ram_cen  = 1'b1;
    bus_if.ram_wen  = 1'b0;
    bus_if.ram_addr = addr;
    @(negedge clk);
    data = bus_if.ram_rdata;
    bus_if.ram_cen  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_vec++;
    if (txd !== 1'b1) begin
      n_err++; $display("FAIL reset_txd: got %b want 1", txd);
    end
    n_vec++;
    if (tx_irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want 0", tx_irq);
    end
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL reset_status: got %h want 00000000", rd);
    end
    bus_read(BASE + 32'h8, rd);
    n_vec++;
    if (rd !== 32'h0000_01B1) begin
      n_err++; $display("FAIL reset_div: got %h want 000001b1", rd);
    end
    n_vec++;
    if (bus_if.ram_rdata !== 32'h0) begin
      idle_cycles(0);
    end
    @(negedge clk);
    n_vec++;
    if (bus_if.ram_rdata !== 32'h0) begin
      n_err++; $display("FAIL rdata_idle_zero: got %h want 00000000", bus_if.ram_rdata);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    bus_read(BASE + 32'h4, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL data_read_zero: got %h want 00000000", rd);
    end
    bus_write(BASE + 32'h8, 32'h0000_1234, 4'b0011);
    bus_read(BASE + 32'h8, rd);
    n_vec++;
    if (rd !== 32'h0000_1234) begin
      n_err++; $display("FAIL div_rw: got %h want 00001234", rd);
    end
    bus_write(BASE + 32'h8, 32'h0000_FF00, 4'b0001);
    bus_read(BASE + 32'h8, rd);
    n_vec++;
    if (rd !== 32'h0000_1200) begin
      n_err++; $display("FAIL div_lane0: got %h want 00001200", rd);
    end
    bus_write(32'hE000_0018, 32'h0000_5555, 4'b1111);
    bus_write(BASE + 32'h2, 32'h0000_5555, 4'b1111);
    bus_read(BASE + 32'h8, rd);
    n_vec++;
    if (rd !== 32'h0000_1200) begin
      n_err++; $display("FAIL div_outside_write: got %h want 00001200", rd);
    end
    bus_read(BASE + 32'h1, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL hole_read: got %h want 00000000", rd);
    end
    bus_read(32'hE000_0108, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL outside_read: got %h want 00000000", rd);
    end
    bus_write(BASE + 32'hC, 32'hFFFF_FFFE, 4'b1111);
    bus_read(BASE + 32'hC, rd);
    n_vec++;
`ifdef UART_TX_PARITY_EN
    if (rd !== 32'h0000_0006) begin
      n_err++; $display("FAIL ctrl_rw: got %h want 00000006", rd);
    end
`else
    if (rd !== 32'h0000_0000) begin
      n_err++; $display("FAIL ctrl_rw: got %h want 00000000", rd);
    end
`endif
    bus_write(BASE + 32'hC, 32'h0, 4'b0001);
  endtask

  task automatic test_single_frame();
    logic [9:0] fr;
    fr = {1'b1, 8'h41, 1'b0};
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    bus_write(BASE + 32'h4, 32'h41, 4'b0001);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      n_vec++;
      if (txd !== fr[j / 4]) begin
        n_err++; $display("FAIL frame41 cycle %0d: got %b want %b", j, txd, fr[j / 4]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (txd !== 1'b1) begin
      n_err++; $display("FAIL frame41_idle: got %b want 1", txd);
    end
  endtask

  task automatic test_busy();
    logic [31:0] rd;
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    bus_write(BASE + 32'h4, 32'h5A, 4'b0001);
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0000_0102) begin
      n_err++; $display("FAIL busy_start: got %h want 00000102", rd);
    end
    idle_cycles(10);
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0000_0002) begin
      n_err++; $display("FAIL busy_mid: got %h want 00000002", rd);
    end
    idle_cycles(40);
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL busy_done: got %h want 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] seq;
    seq = {1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    bus_write(BASE + 32'h8, 32'd0, 4'b0011);
    bus_write(BASE + 32'h4, 32'hA5, 4'b0001);
    bus_write(BASE + 32'h4, 32'h3C, 4'b0001);
    for (int j = 0; j < 22; j++) begin
      if (j > 0) @(negedge clk);
      n_vec++;
      if (txd !== seq[j]) begin
        n_err++; $display("FAIL b2b cycle %0d: got %b want %b", j, txd, seq[j]);
      end
    end
  endtask

  task automatic test_irq();
    bus_write(BASE + 32'h8, 32'd0, 4'b0011);
    bus_write(BASE + 32'hC, 32'h1, 4'b0001);
    @(negedge clk);
    n_vec++;
    if (tx_irq !== 1'b1) begin
      n_err++; $display("FAIL irq_idle: got %b want 1", tx_irq);
    end
    bus_write(BASE + 32'h4, 32'h81, 4'b0001);
    for (int k = 2; k <= 13; k++) begin
      @(negedge clk);
      n_vec++;
      if (tx_irq !== (k == 13)) begin
        n_err++; $display("FAIL irq cycle %0d: got %b want %b", k, tx_irq, (k == 13));
      end
    end
    bus_write(BASE + 32'hC, 32'h0, 4'b0001);
    @(negedge clk);
    n_vec++;
    if (tx_irq !== 1'b0) begin
      n_err++; $display("FAIL irq_disable: got %b want 0", tx_irq);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    bus_write(BASE + 32'h8, 32'd100, 4'b0011);
    for (int i = 0; i < 18; i++) bus_write(BASE + 32'h4, 32'(i * 3), 4'b0001);
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0000_1007) begin
      n_err++; $display("FAIL overflow_status: got %h want 00001007", rd);
    end
    bus_write(BASE, 32'h4, 4'b0001);
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0000_1003) begin
      n_err++; $display("FAIL overflow_clear: got %h want 00001003", rd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    idle_cycles(150);
    n_vec++;
    if (txd !== 1'b0) begin
      n_err++; $display("FAIL mid_data_low: got %b want 0", txd);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (txd !== 1'b1) begin
      n_err++; $display("FAIL reset_async_txd: got %b want 1", txd);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(BASE, rd);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL reset_fifo_flush: got %h want 00000000", rd);
    end
    idle_cycles(5);
    n_vec++;
    if (txd !== 1'b1) begin
      n_err++; $display("FAIL reset_stays_idle: got %b want 1", txd);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] fr;
    bus_write(BASE + 32'h8, 32'd0, 4'b0011);
    for (int p = 0; p < 2; p++) begin
      bus_write(BASE + 32'hC, (p == 0) ? 32'h2 : 32'h6, 4'b0001);
      fr = {1'b1, p[0], 8'h03, 1'b0};
      bus_write(BASE + 32'h4, 32'h03, 4'b0001);
      for (int j = 0; j < 11; j++) begin
        @(negedge clk);
        n_vec++;
        if (txd !== fr[j]) begin
          n_err++; $display("FAIL parity%0d bit %0d: got %b want %b", p, j, txd, fr[j]);
        end
      end
      idle_cycles(3);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.ram_cen   = 1'b0;
    bus_if.ram_wen   = 1'b0;
    bus_if.ram_flag  = 4'h0;
    bus_if.ram_addr  = 32'h0;
    bus_if.ram_wdata = 32'h0;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_single_frame();
    idle_cycles(3);
    test_busy();
    idle_cycles(3);
    test_back_to_back();
    idle_cycles(3);
    test_irq();
    idle_cycles(3);
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
